// File: rtl/chunked_adder_pkg.sv
// Shared definitions for the multi-cycle chunked adder: FSM state encoding,
// the full-adder cell used by the chunk ripple, and the index-width helper.
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic s;
    logic c;
  } fa_t;

  // One-bit full adder cell: sum and carry of a + b + ci.
  function automatic fa_t full_add(input logic a, input logic b, input logic ci);
    fa_t r;
    r.s = a ^ b ^ ci;
    r.c = (a & b) | (a & ci) | (b & ci);
    return r;
  endfunction

  // Bits needed to count 0..n-1, never less than one so a single-chunk
  // configuration still has a legal counter.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/chunked_adder_chunk.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells.
// With OVERFLOW_FLAG_EN defined it also exposes the carry into its MSB so the
// top level can form the signed overflow flag on the final chunk.
module chunk_adder
  import chunked_adder_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             cmsb
`endif
);

  logic [CHUNK:0] carry;

  // Ripple the carry from bit 0 up through every cell of the chunk.
  always_comb begin
    fa_t fa;
    // NOTE: every variable written here gets a default first, so no path can
    // leave a stale value behind and infer a latch.
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      fa           = full_add(a[i], b[i], carry[i]);
      sum[i]       = fa.s;
      carry[i + 1] = fa.c;
    end
  end

  assign cout = carry[CHUNK];

`ifdef OVERFLOW_FLAG_EN
  assign cmsb = carry[CHUNK-1];
`endif

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle N-bit adder: Sum = A + B + Cin, computed CHUNK bits per clock
// with a registered carry between chunks. Valid/ready handshake on both the
// operand and result sides; one operation in flight at a time.
// Optional feature: define OVERFLOW_FLAG_EN to add the Ovf (signed overflow)
// output; without it the port and its register are absent.
module chunked_adder
  import chunked_adder_pkg::*;
#(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic         Ovf
`endif
);

  localparam int NUM_CHUNKS = N / CHUNK;
  localparam int IDX_W      = idx_width(NUM_CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  // Reject configurations where the operand does not split into whole chunks.
  if ((N % CHUNK) != 0 || N < CHUNK) begin : g_bad_cfg
    $error("chunked_adder: N must be a positive multiple of CHUNK");
  end

  state_e             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [N-1:0]       a_q;
  logic [N-1:0]       b_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic [N-1:0]       sum_q;
  logic               cout_q;

  // Combinational result of the chunk currently selected by idx_q.
  logic [CHUNK-1:0]   chunk_a;
  logic [CHUNK-1:0]   chunk_b;
  logic [CHUNK-1:0]   chunk_sum_d;
  logic               chunk_cout_d;

  assign chunk_a = a_q[idx_q*CHUNK +: CHUNK];
  assign chunk_b = b_q[idx_q*CHUNK +: CHUNK];

`ifdef OVERFLOW_FLAG_EN
  logic chunk_cmsb_d;
  logic ovf_q;
`endif

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry_q),
    .sum  (chunk_sum_d),
    .cout (chunk_cout_d)
`ifdef OVERFLOW_FLAG_EN
    ,
    .cmsb (chunk_cmsb_d)
`endif
  );

  // Handshake FSM plus operand, carry, index and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Operands are cleared with everything else so an aborted operation
      // leaves nothing behind that could leak into the next one.
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // pre-edge values and the block order does not matter.
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= A;
            b_q        <= B;
            carry_q    <= Cin;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_RUN;
          end
        end

        ST_RUN: begin
          sum_q[idx_q*CHUNK +: CHUNK] <= chunk_sum_d;
          carry_q                     <= chunk_cout_d;
          if (idx_q == LAST_IDX) begin
            cout_q      <= chunk_cout_d;
`ifdef OVERFLOW_FLAG_EN
            // Signed overflow: carry into the MSB differs from carry out.
            ovf_q       <= chunk_cmsb_d ^ chunk_cout_d;
`endif
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end

        ST_DONE: begin
          // Result is held until taken; accept opens only the cycle after.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;

`ifdef OVERFLOW_FLAG_EN
  assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder. Three instances share one stimulus
// stream: N=32/CHUNK=8, N=16/CHUNK=4 and N=8/CHUNK=8, each fed the low bits
// of the shared operands. Results are compared against a plain-arithmetic
// model of A + B + Cin. Define OVERFLOW_FLAG_EN to also check Ovf.
module tb_chunked_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        Cin;
  logic [31:0] A;
  logic [31:0] B;

  logic        rdy32, rdy16, rdy8;
  logic        v32, v16, v8;
  logic [31:0] s32;
  logic [15:0] s16;
  logic [7:0]  s8;
  logic        c32, c16, c8;
`ifdef OVERFLOW_FLAG_EN
  logic        o32, o16, o8;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] last_sum32;
  logic        last_cout32;
  logic        last_ovf32;

  always #5 clk = ~clk;

  chunked_adder #(.N(32), .CHUNK(8)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
    .A(A), .B(B), .Cin(Cin), .out_valid(v32), .out_ready(out_ready),
    .Sum(s32), .Cout(c32)
`ifdef OVERFLOW_FLAG_EN
    , .Ovf(o32)
`endif
  );

  chunked_adder #(.N(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16),
    .A(A[15:0]), .B(B[15:0]), .Cin(Cin), .out_valid(v16), .out_ready(out_ready),
    .Sum(s16), .Cout(c16)
`ifdef OVERFLOW_FLAG_EN
    , .Ovf(o16)
`endif
  );

  chunked_adder #(.N(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
    .A(A[7:0]), .B(B[7:0]), .Cin(Cin), .out_valid(v8), .out_ready(out_ready),
    .Sum(s8), .Cout(c8)
`ifdef OVERFLOW_FLAG_EN
    , .Ovf(o8)
`endif
  );

  // Per-instance views: index 0 = 32-bit, 1 = 16-bit, 2 = 8-bit.
  function automatic int wid(input int d);
    return (d == 0) ? 32 : (d == 1) ? 16 : 8;
  endfunction

  function automatic int lat(input int d);
    return wid(d) / ((d == 1) ? 4 : 8);
  endfunction

  function automatic logic get_rdy(input int d);
    return (d == 0) ? rdy32 : (d == 1) ? rdy16 : rdy8;
  endfunction

  function automatic logic get_v(input int d);
    return (d == 0) ? v32 : (d == 1) ? v16 : v8;
  endfunction

  function automatic logic [31:0] get_sum(input int d);
    return (d == 0) ? s32 : (d == 1) ? {16'h0, s16} : {24'h0, s8};
  endfunction

  function automatic logic get_cout(input int d);
    return (d == 0) ? c32 : (d == 1) ? c16 : c8;
  endfunction

`ifdef OVERFLOW_FLAG_EN
  function automatic logic get_ovf(input int d);
    return (d == 0) ? o32 : (d == 1) ? o16 : o8;
  endfunction
`endif

  // Reference: {ovf, cout, sum} for w-bit operands, from integer arithmetic.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic c, input int w);
    longint unsigned mask, total;
    longint sa, sb, st, lim;
    logic ovf;
    mask  = (64'd1 << w) - 64'd1;
    total = (64'(a) & mask) + (64'(b) & mask) + 64'(c);
    sa = longint'(64'(a) & mask);
    sb = longint'(64'(b) & mask);
    if (a[w-1]) sa = sa - longint'(64'd1 << w);
    if (b[w-1]) sb = sb - longint'(64'd1 << w);
    st  = sa + sb + longint'(c);
    lim = longint'(64'd1 << (w - 1));
    ovf = (st >= lim) || (st < -lim);
    return {ovf, total[w], 32'(total & mask)};
  endfunction

  // One full transaction on all instances with out_ready held high.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic c, input string tag);
    bit seen[3];
    logic [33:0] exp;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (get_rdy(d) !== 1'b1) begin
        n_bad++;
        $display("FAIL %s in_ready d%0d: got %b want 1", tag, d, get_rdy(d));
      end
      seen[d] = 1'b0;
    end
    A = a; B = b; Cin = c; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom; B = $urandom; Cin = 1'($urandom);
    for (int k = 1; k <= 16 && !(seen[0] && seen[1] && seen[2]); k++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (!seen[d] && get_v(d)) begin
          seen[d] = 1'b1;
          exp = model(a, b, c, wid(d));
          n_cmp++;
          if (k != lat(d)) begin
            n_bad++;
            $display("FAIL %s latency d%0d: got %0d want %0d", tag, d, k, lat(d));
          end
          n_cmp++;
          if (get_sum(d) !== exp[31:0]) begin
            n_bad++;
            $display("FAIL %s sum d%0d: got %h want %h", tag, d, get_sum(d), exp[31:0]);
          end
          n_cmp++;
          if (get_cout(d) !== exp[32]) begin
            n_bad++;
            $display("FAIL %s cout d%0d: got %b want %b", tag, d, get_cout(d), exp[32]);
          end
`ifdef OVERFLOW_FLAG_EN
          n_cmp++;
          if (get_ovf(d) !== exp[33]) begin
            n_bad++;
            $display("FAIL %s ovf d%0d: got %b want %b", tag, d, get_ovf(d), exp[33]);
          end
          if (d == 0) last_ovf32 = o32;
`endif
          if (d == 0) begin
            last_sum32  = s32;
            last_cout32 = c32;
          end
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      if (!seen[d]) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s timeout d%0d: got no out_valid want it within %0d cycles",
                 tag, d, lat(d));
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (get_rdy(d) !== 1'b1 || get_v(d) !== 1'b0 ||
          get_sum(d) !== 32'h0 || get_cout(d) !== 1'b0) begin
        n_bad++;
        $display("FAIL %s d%0d: got rdy=%b v=%b sum=%h cout=%b want 1 0 0 0",
                 tag, d, get_rdy(d), get_v(d), get_sum(d), get_cout(d));
      end
`ifdef OVERFLOW_FLAG_EN
      n_cmp++;
      if (get_ovf(d) !== 1'b0) begin
        n_bad++;
        $display("FAIL %s ovf d%0d: got %b want 0", tag, d, get_ovf(d));
      end
`endif
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Cin = 1'b0;
    #1;
    check_reset_values("reset_async");
    repeat (2) @(negedge clk);
    check_reset_values("reset_held");
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, "small");
    n_cmp++;
    if (last_sum32 !== 32'h0000_0008 || last_cout32 !== 1'b0) begin
      n_bad++;
      $display("FAIL small_const: got %h/%b want 00000008/0", last_sum32, last_cout32);
    end
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "ripple");
    n_cmp++;
    if (last_sum32 !== 32'h0000_0000 || last_cout32 !== 1'b1) begin
      n_bad++;
      $display("FAIL ripple_const: got %h/%b want 00000000/1", last_sum32, last_cout32);
    end
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "ovf");
    n_cmp++;
    if (last_sum32 !== 32'h8000_0000 || last_cout32 !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_const: got %h/%b want 80000000/0", last_sum32, last_cout32);
    end
`ifdef OVERFLOW_FLAG_EN
    n_cmp++;
    if (last_ovf32 !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_flag_const: got %b want 1", last_ovf32);
    end
`endif
  endtask

  task automatic test_hold();
    logic [33:0] exp;
    bit got;
    exp = model(32'h1234_5678, 32'hF111_1111, 1'b1, 32);
    @(negedge clk);
    A = 32'h1234_5678; B = 32'hF111_1111; Cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      @(negedge clk);
      got = v32;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL hold timeout: got no out_valid want within 4 cycles");
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; A = $urandom; B = $urandom; Cin = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if (v32 !== 1'b1 || rdy32 !== 1'b0 || s32 !== exp[31:0] || c32 !== exp[32]) begin
        n_bad++;
        $display("FAIL hold cyc%0d: got v=%b rdy=%b sum=%h cout=%b want 1 0 %h %b",
                 i, v32, rdy32, s32, c32, exp[31:0], exp[32]);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (v32 !== 1'b0 || rdy32 !== 1'b1) begin
      n_bad++;
      $display("FAIL handoff: got v=%b rdy=%b want 0 1", v32, rdy32);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D; Cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_values("reset_mid");
    @(negedge clk);
    rst = 1'b0;
    run_op(32'h1, 32'h1, 1'b0, "after_rst");
    n_cmp++;
    if (last_sum32 !== 32'h2 || last_cout32 !== 1'b0) begin
      n_bad++;
      $display("FAIL after_rst_const: got %h/%b want 00000002/0", last_sum32, last_cout32);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 5))
        0:       begin a = 32'hFFFF_FFFF; b = $urandom; end
        1:       begin a = 32'h7F7F_7F7F; b = 32'h0101_0101; end
        2:       begin a = 32'h8080_8080; b = 32'h8080_8080; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      run_op(a, b, 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
